// File: rtl/led_pattern_pkg.sv
// rtl/led_pattern_pkg.sv - mode, handshake-state and PWM constants shared by the LED pattern generator
package led_pattern_pkg;

  // Width of the mode request field.
  localparam int MODE_W = 2;

  // Width of the free-running PWM counter.
  localparam int PWM_W = 8;

  // Pattern modes as seen on the mode request field.
  typedef enum logic [MODE_W-1:0] {
    MODE_COUNT = 2'd0,
    MODE_SCAN  = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_FILL  = 2'd3
  } mode_e;

  // Mode-request handshake states.
  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_PENDING = 1'b1
  } state_e;

endpackage

// File: rtl/led_pattern_gen_if.sv
// rtl/led_pattern_gen_if.sv - mode request valid/ready bundle for led_pattern_gen
interface led_pattern_gen_if;
  import led_pattern_pkg::*;

  logic [MODE_W-1:0] mode;
  logic              mode_valid;
  logic              mode_ready;

  modport master (output mode, output mode_valid, input mode_ready);
  modport slave  (input mode, input mode_valid, output mode_ready);

endinterface

// File: rtl/led_tick_div.sv
// rtl/led_tick_div.sv - prescaler counting 0..DIV-1, flags the wrap edge
module led_tick_div #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic reset,
  output logic tick_en
);

  // Guarded so an illegal DIV still elaborates far enough to report the error.
  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  if (DIV < 2) begin : g_div_check
    $error("led_tick_div: DIV must be at least 2");
  end

  logic [CNT_W-1:0] cnt;

  // Wrapping step counter; the edge with cnt == LAST is the step edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick_en = (cnt == LAST);

endmodule

// File: rtl/led_pattern_gen.sv
// rtl/led_pattern_gen.sv - LED pattern generator (COUNT/SCAN/BLINK/FILL); macro LED_PWM_EN enables PWM dimming
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int NUM_LEDS       = 6,
  parameter int CLK_HZ         = 27_000_000,
  parameter int STEP_HZ        = 10,
  parameter int LED_ACTIVE_LOW = 1,
  parameter int DUTY           = 255
) (
  input  logic                clk,
  input  logic                reset,
  led_pattern_gen_if.slave    mode_if,
  output logic [NUM_LEDS-1:0] led,
  output logic                test_pin,
  output logic                tick
);

  localparam int DIV = CLK_HZ / STEP_HZ;

  if (NUM_LEDS < 1 || NUM_LEDS > 32) begin : g_leds_check
    $error("led_pattern_gen: NUM_LEDS must be in 1..32");
  end

  if (DUTY < 0 || DUTY > 255) begin : g_duty_check
    $error("led_pattern_gen: DUTY must be in 0..255");
  end

  typedef logic [NUM_LEDS-1:0] pat_t;

  localparam pat_t ALL_ONES = {NUM_LEDS{1'b1}};
  localparam pat_t BIT0     = pat_t'(1);

  state_e state;
  state_e state_nxt;
  mode_e  mode_cur;
  mode_e  mode_pend;
  pat_t   pattern;
  pat_t   pattern_adv;
  pat_t   lit;
  logic   dir_up;
  logic   dir_up_adv;
  logic   tick_en;
  logic   accept;

  // Value a mode starts from when it is (re)loaded.
  function automatic pat_t load_value(input mode_e m);
    case (m)
      MODE_SCAN:  return BIT0;
      MODE_BLINK: return ALL_ONES;
      default:    return '0;
    endcase
  endfunction

  led_tick_div #(
    .DIV(DIV)
  ) u_tick_div (
    .clk     (clk),
    .reset   (reset),
    .tick_en (tick_en)
  );

  assign accept = mode_if.mode_valid && (state == ST_RUN);

  // Handshake state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // A request waits in PENDING until the next step edge applies it.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:     if (mode_if.mode_valid) state_nxt = ST_PENDING;
      ST_PENDING: if (tick_en) state_nxt = ST_RUN;
      default:    state_nxt = ST_RUN;
    endcase
  end

  // Ready only while no request is waiting to be applied.
  always_comb begin
    mode_if.mode_ready = (state == ST_RUN);
  end

  // One step of the active mode's sequence.
  always_comb begin
    pattern_adv = pattern;
    dir_up_adv  = dir_up;
    case (mode_cur)
      MODE_COUNT: begin
        pattern_adv = pattern + BIT0;
      end
      MODE_SCAN: begin
        if (NUM_LEDS == 1) begin
          pattern_adv = BIT0;
        end else if (dir_up) begin
          if (pattern[NUM_LEDS-1]) begin
            pattern_adv = pattern >> 1;
            dir_up_adv  = 1'b0;
          end else begin
            pattern_adv = pattern << 1;
          end
        end else begin
          if (pattern[0]) begin
            pattern_adv = pattern << 1;
            dir_up_adv  = 1'b1;
          end else begin
            pattern_adv = pattern >> 1;
          end
        end
      end
      MODE_BLINK: begin
        pattern_adv = (pattern == '0) ? ALL_ONES : '0;
      end
      MODE_FILL: begin
        pattern_adv = (pattern == ALL_ONES) ? '0 : ((pattern << 1) | BIT0);
      end
      default: begin
        pattern_adv = pattern;
      end
    endcase
  end

  // Pattern, mode, direction, tick and test_pin all change on step edges;
  // a pending request replaces that step's advance with the new mode's load value.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mode_cur  <= MODE_COUNT;
      mode_pend <= MODE_COUNT;
      pattern   <= '0;
      dir_up    <= 1'b1;
      tick      <= 1'b0;
      test_pin  <= 1'b0;
    end else begin
      tick <= tick_en;
      if (accept) begin
        mode_pend <= mode_e'(mode_if.mode);
      end
      if (tick_en) begin
        test_pin <= ~test_pin;
        if (state == ST_PENDING) begin
          mode_cur <= mode_pend;
          pattern  <= load_value(mode_pend);
          dir_up   <= 1'b1;
        end else begin
          pattern <= pattern_adv;
          dir_up  <= dir_up_adv;
        end
      end
    end
  end

`ifdef LED_PWM_EN
  localparam logic [PWM_W-1:0] DUTY_CMP = PWM_W'(DUTY);

  logic [PWM_W-1:0] pwm_cnt;

  // Free-running PWM period counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  assign lit = (pwm_cnt < DUTY_CMP) ? pattern : '0;
`else
  assign lit = pattern;
`endif

  assign led = (LED_ACTIVE_LOW != 0) ? ~lit : lit;

endmodule

// File: doc/led_pattern_gen.md
LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

Interface
REQ-001 Parameter NUM_LEDS, default 6, LED count; legal range 1..32.
REQ-002 Parameter CLK_HZ, default 27_000_000, input clock frequency.
REQ-003 Parameter STEP_HZ, default 10, pattern step rate; DIV = CLK_HZ/STEP_HZ (integer division); DIV >= 2 is required, else elaboration error.
REQ-004 Parameter LED_ACTIVE_LOW, default 1; when 1, led = ~pattern; when 0, led = pattern.
REQ-005 Parameter DUTY, default 255, PWM compare value 0..255 (used only under LED_PWM_EN).
REQ-006 clk  in  1  single system clock; all logic on rising edge.
REQ-007 reset  in  1  synchronous, active-low reset.
REQ-008 mode  in  2  requested mode: 0 COUNT, 1 SCAN, 2 BLINK, 3 FILL.
REQ-009 mode_valid  in  1  mode request strobe.
REQ-010 mode_ready  out  1  block can accept a mode request.
REQ-011 led  out  NUM_LEDS  LED drive, polarity per LED_ACTIVE_LOW.
REQ-012 test_pin  out  1  toggles on every step tick.
REQ-013 tick  out  1  one-cycle pulse marking a pattern step.

Function
REQ-014 Prescaler counts 0..DIV-1 and wraps; on the edge where the count equals DIV-1, the pattern advances, test_pin toggles and tick is 1 for the following cycle only.
REQ-015 New pattern and tick=1 are visible in the same cycle; tick period is exactly DIV clocks.
REQ-016 COUNT: pattern increments by 1 per tick, modulo 2^NUM_LEDS; load value 0.
REQ-017 SCAN: single lit bit bouncing 0->NUM_LEDS-1->0; direction flips at either end without repeating the end position; load value bit0, direction up; NUM_LEDS=1 holds bit0.
REQ-018 BLINK: pattern alternates all-ones/all-zeros per tick; load value all-ones.
REQ-019 FILL: thermometer 0, 1, 3, 7, ... all-ones, then 0 and repeat (NUM_LEDS+1 steps); load value 0.
REQ-020 Handshake FSM states RUN and PENDING; mode_ready = 1 in RUN, 0 in PENDING.
REQ-021 RUN: mode_valid & mode_ready captures mode and enters PENDING next cycle; mode_valid in PENDING is ignored.
REQ-022 PENDING: at the next tick edge, the captured mode is loaded, pattern takes that mode's load value (no advance that step), SCAN direction resets to up, FSM returns to RUN.
REQ-023 Request accepted in the same cycle as a tick edge is applied at the following tick, not the current one.
REQ-024 Request for the current mode is accepted and restarts that mode from its load value.

Reset
REQ-025 While reset = 0 at a clock edge: prescaler 0, mode COUNT, pattern 0, SCAN direction up, FSM RUN, mode_ready 1, tick 0, test_pin 0, led all-off (all-ones when LED_ACTIVE_LOW = 1).
REQ-026 Reset mid-operation discards any pending request; first tick after release occurs DIV clocks after the first edge with reset = 1.

Configuration
REQ-027 Macro LED_PWM_EN defined: a free-running 8-bit counter gates the output; each lit bit appears lit only while counter < DUTY (DUTY=0 always off, 255 lit 255/256); pattern, tick and test_pin are unaffected.
REQ-028 LED_PWM_EN undefined: no PWM counter; led driven directly from pattern; DUTY ignored.

Structure
REQ-029 Package led_pattern_pkg holds mode constants (MODE_COUNT..MODE_FILL), FSM state encoding, and the PWM counter width constant.
REQ-030 Prescaler is sub-module led_tick_div (parameter DIV; ports clk, reset, tick_en), instantiated once.

Verification (CLK_HZ=100, STEP_HZ=10 -> DIV=10, LED_ACTIVE_LOW=1 unless stated)
REQ-031 Reset release, COUNT, NUM_LEDS=6 -> after 3 ticks (30 clocks) led = 6'b111100; after 64 ticks led = 6'b111111.
REQ-032 SCAN request, NUM_LEDS=4, LED_ACTIVE_LOW=0 -> per tick 0001, 0010, 0100, 1000, 0100, 0010, 0001.
REQ-033 mode=2 with mode_valid at clock 4 of an interval -> mode_ready 0 from clock 5 until the tick; led all-on at that tick; mode_ready 1 in the cycle after.
REQ-034 Reset asserted during FILL at pattern 0111 -> next cycle led all-off, test_pin 0, mode_ready 1; after release, COUNT resumes from 0.
REQ-035 Free run for 100 clocks -> exactly 10 tick pulses, each 1 cycle wide; test_pin toggles every 10 clocks.
REQ-036 LED_PWM_EN, DUTY=64, BLINK all-on -> every LED lit exactly 64 of 256 consecutive cycles.
